// File: rtl/toast_muldiv_pkg.sv
// rtl/toast_muldiv_pkg.sv - shared M-extension encodings, muldiv FSM states and op helpers
package toast_muldiv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // Decoder steering: an OP-class instruction with funct7 0000001 belongs to this unit.
  function automatic logic md_decode_hit(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic md_op1_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_op2_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/toast_muldiv_step.sv
// rtl/toast_muldiv_step.sv - one UNROLL-wide iteration slice: shift-add multiply or restoring divide
module toast_muldiv_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_t;

  // Multiply: {hi,lo} holds partial product above the not-yet-consumed multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    w_hi = i_hi;
    w_lo = i_lo;
    w_t  = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (i_div) begin
        w_t  = {w_hi, w_lo[XLEN-1]};
        w_lo = {w_lo[XLEN-2:0], 1'b0};
        if (w_t >= {1'b0, i_b}) begin
          w_t     = w_t - {1'b0, i_b};
          w_lo[0] = 1'b1;
        end
        w_hi = w_t[XLEN-1:0];
      end else begin
        w_t  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_b} : '0);
        w_lo = {w_t[0], w_lo[XLEN-1:1]};
        w_hi = w_t[XLEN:1];
      end
    end
    o_hi = w_hi;
    o_lo = w_lo;
  end

endmodule

// File: rtl/toast_muldiv.sv
// rtl/toast_muldiv.sv - iterative RV32 M-extension multiply/divide unit with valid/ready and flush
module toast_muldiv
  import toast_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_hi, r_lo, r_b, r_result;
  logic            r_neg_a, r_neg_b;

  logic            w_accept, w_last;
  logic            w_neg1, w_neg2, w_div0, w_ovf, w_fast;
  logic [XLEN-1:0] w_abs1, w_abs2, w_fast_res;
  logic [XLEN-1:0] w_step_hi, w_step_lo;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0] w_quo, w_rem, w_fix_res;

  assign ready_o  = (r_state == MD_IDLE);
  assign valid_o  = (r_state == MD_DONE);
  assign busy_o   = (r_state != MD_IDLE);
  assign result_o = r_result;

  assign w_accept = valid_i & ready_o & ~kill_i;
  assign w_last   = (r_cnt == CW'(N - 1));

  // Operands are latched as magnitudes; signs are restored in FIX.
  assign w_neg1 = md_op1_signed(op_i) & op1_i[XLEN-1];
  assign w_neg2 = md_op2_signed(op_i) & op2_i[XLEN-1];
  assign w_abs1 = w_neg1 ? -op1_i : op1_i;
  assign w_abs2 = w_neg2 ? -op2_i : op2_i;

  assign w_div0 = md_is_div(op_i) && (op2_i == '0);
  assign w_ovf  = md_is_div(op_i) && md_op1_signed(op_i) &&
                  (op1_i == MOST_NEG) && (op2_i == '1);
  assign w_fast = w_div0 | w_ovf;

  always_comb begin
    w_fast_res = '0;
    if (w_div0) begin
      w_fast_res = md_is_rem(op_i) ? op1_i : '1;
    end else begin
      w_fast_res = md_is_rem(op_i) ? '0 : op1_i;
    end
  end

  toast_muldiv_step #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_step (
    .i_div (md_is_div(r_op)),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .i_b   (r_b),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quo    = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
  assign w_rem    = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      MD_MUL:                      w_fix_res = w_prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             w_fix_res = w_quo;
      default:                     w_fix_res = w_rem;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (w_accept) w_state_nxt = w_fast ? MD_DONE : MD_CALC;
      MD_CALC: if (w_last)   w_state_nxt = MD_FIX;
      MD_FIX:                w_state_nxt = MD_DONE;
      MD_DONE: if (ready_i)  w_state_nxt = MD_IDLE;
      default:               w_state_nxt = MD_IDLE;
    endcase
    if (kill_i) w_state_nxt = MD_IDLE;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_op     <= MD_MUL;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op    <= op_i;
        r_cnt   <= '0;
        r_hi    <= '0;
        r_lo    <= w_abs1;
        r_b     <= w_abs2;
        r_neg_a <= w_neg1;
        r_neg_b <= w_neg2;
        if (w_fast) r_result <= w_fast_res;
      end
      if (r_state == MD_CALC) begin
        r_hi  <= w_step_hi;
        r_lo  <= w_step_lo;
        r_cnt <= r_cnt + CW'(1);
      end
      if ((r_state == MD_FIX) && !kill_i) r_result <= w_fix_res;
    end
  end

endmodule

// File: tb/tb_toast_muldiv.sv
// tb/tb_toast_muldiv.sv - randomized and directed checks of toast_muldiv at UNROLL=1 and UNROLL=4
module tb_toast_muldiv;
  import toast_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid_i = 1'b0;
  logic        kill_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic        rdy1, vld1, busy1, rdy4, vld4, busy4;
  logic [31:0] res1, res4;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  toast_muldiv #(.XLEN(32), .UNROLL(1)) u_dut1 (
    .clk_i(clk), .resetn_i(resetn), .valid_i(valid_i), .ready_o(rdy1),
    .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i), .kill_i(kill_i),
    .valid_o(vld1), .ready_i(ready_i), .result_o(res1), .busy_o(busy1)
  );

  toast_muldiv #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .clk_i(clk), .resetn_i(resetn), .valid_i(valid_i), .ready_o(rdy4),
    .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i), .kill_i(kill_i),
    .valid_o(vld4), .ready_i(ready_i), .result_o(res4), .busy_o(busy4)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact 64-bit arithmetic, truncated to 32 bits.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    up = {32'h0, a} * {32'h0, b};
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  return up[63:32];
      MD_DIV:    begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      MD_DIVU:   begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      MD_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic logic ref_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return ((op == MD_DIV) || (op == MD_REM)) && (a == 32'h80000000) && (b == 32'hFFFFFFFF);
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp, got1, got4;
    int          lat1, lat4;
    logic        fast;
    exp  = ref_md(op, a, b);
    fast = ref_fast(op, a, b);
    lat1 = 0; lat4 = 0; got1 = '0; got4 = '0;
    @(negedge clk);
    op_i = op; op1_i = a; op2_i = b; ready_i = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      valid_i = 1'b0;
      if (lat1 == 0 && vld1) begin lat1 = c; got1 = res1; end
      if (lat4 == 0 && vld4) begin lat4 = c; got4 = res4; end
      if (lat1 != 0 && lat4 != 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    expect_eq($sformatf("op%0d %h,%h result u1", op, a, b), got1, exp);
    expect_eq($sformatf("op%0d %h,%h result u4", op, a, b), got4, exp);
    expect_eq($sformatf("op%0d latency u1", op), lat1, fast ? 32'd1 : 32'd34);
    expect_eq($sformatf("op%0d latency u4", op), lat4, fast ? 32'd1 : 32'd10);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return $urandom_range(0, 20);
      4:       return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    logic        seen;

    repeat (3) @(negedge clk);
    expect_eq("reset ready_o", rdy1, 1'b1);
    expect_eq("reset valid_o", vld1, 1'b0);
    expect_eq("reset busy_o", busy1, 1'b0);
    expect_eq("reset result_o", res1, 32'h0);
    resetn = 1'b1;

    run_op(MD_MUL,    32'd7,        32'hFFFFFFFD);
    run_op(MD_MULHU,  32'd7,        32'hFFFFFFFD);
    run_op(MD_MULH,   32'h80000000, 32'h80000000);
    run_op(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(MD_DIV,    32'hFFFFFFF9, 32'd2);
    run_op(MD_REM,    32'hFFFFFFF9, 32'd2);
    run_op(MD_DIVU,   32'd100,      32'd7);
    run_op(MD_REMU,   32'd100,      32'd7);
    run_op(MD_DIV,    32'd5,        32'd0);
    run_op(MD_REM,    32'd5,        32'd0);
    run_op(MD_DIV,    32'h80000000, 32'hFFFFFFFF);
    run_op(MD_REM,    32'h80000000, 32'hFFFFFFFF);
    run_op(MD_DIVU,   32'h80000000, 32'hFFFFFFFF);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb);
    end

    // Backpressure: result held, new requests ignored, ready_o returns after handshake.
    @(negedge clk);
    op_i = MD_MULHU; op1_i = 32'd7; op2_i = 32'hFFFFFFFD; ready_i = 1'b0; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    for (int c = 0; c < 60 && !vld1; c++) @(negedge clk);
    expect_eq("bp valid_o asserted", vld1, 1'b1);
    held = res1;
    expect_eq("bp result", held, 32'd6);
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1; op_i = MD_MUL; op1_i = $urandom; op2_i = $urandom;
      @(negedge clk);
      expect_eq("bp valid_o held", vld1, 1'b1);
      expect_eq("bp result held", res1, held);
      expect_eq("bp ready_o low", rdy1, 1'b0);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    expect_eq("bp release ready_o u1", rdy1, 1'b1);
    expect_eq("bp release ready_o u4", rdy4, 1'b1);
    expect_eq("bp release valid_o", vld1, 1'b0);
    expect_eq("idle result held", res1, 32'd6);
    @(negedge clk);
    expect_eq("bp no queued op", busy1, 1'b0);

    // Kill during CALC.
    op_i = MD_DIVU; op1_i = 32'd1000; op2_i = 32'd7; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    expect_eq("kill ready_o u1", rdy1, 1'b1);
    expect_eq("kill busy_o u1", busy1, 1'b0);
    expect_eq("kill ready_o u4", rdy4, 1'b1);
    @(negedge clk);
    kill_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (vld1 || vld4) seen = 1'b1;
    end
    expect_eq("kill no valid_o", seen, 1'b0);
    run_op(MD_DIVU, 32'd9, 32'd3);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    op_i = MD_MUL; op1_i = 32'd123; op2_i = 32'd456; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (10) @(negedge clk);
    expect_eq("pre-reset busy_o", busy1, 1'b1);
    resetn = 1'b0;
    #1;
    expect_eq("async reset ready_o", rdy1, 1'b1);
    expect_eq("async reset valid_o", vld1, 1'b0);
    expect_eq("async reset busy_o", busy1, 1'b0);
    expect_eq("async reset result u1", res1, 32'h0);
    expect_eq("async reset result u4", res4, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(MD_MUL, 32'd123, 32'd456);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
